// File: rtl/mem_arbiter.sv
// Shares one req/ack memory port between instruction fetch and load/store.
// Data has priority over fetch; a starvation bound, misalignment rejection and a memory timeout are applied.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  output logic        i_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_rd_wr,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic        m_req,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_rd_wr,
  input  logic [31:0] m_rdata,
  input  logic        m_ack
);

  localparam logic [7:0]  STARVE_MAX = 8'(STARVE_LIMIT);
  localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

  state_t      state, state_nxt;
  logic        owner_d;
  logic [7:0]  starve_cnt;
  logic [15:0] wait_cnt;

  logic        grant_vld, grant_d, grant_misal, wait_expired;
  logic [31:0] grant_addr;
  logic        resp_set, resp_owner_d, resp_err;
  logic [31:0] resp_rdata;

  always_comb begin
    grant_vld    = i_req | d_req;
    grant_d      = d_req & (~i_req | (starve_cnt < STARVE_MAX));
    grant_addr   = grant_d ? d_addr : i_addr;
    grant_misal  = grant_addr[1:0] != 2'b00;
    wait_expired = wait_cnt == WAIT_LAST;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    m_req        = 1'b0;
    i_ack        = 1'b0;
    d_ack        = 1'b0;
    resp_set     = 1'b0;
    resp_owner_d = owner_d;
    resp_err     = 1'b0;
    resp_rdata   = '0;
    case (state)
      IDLE: begin
        resp_owner_d = grant_d;
        if (grant_vld) begin
          state_nxt = grant_misal ? RESP : MEM;
          resp_set  = grant_misal;
          resp_err  = 1'b1;
        end
      end
      MEM: begin
        m_req = 1'b1;
        if (m_ack) begin
          state_nxt  = RESP;
          resp_set   = 1'b1;
          resp_rdata = m_rd_wr ? m_rdata : '0;
        end else if (wait_expired) begin
          state_nxt = RESP;
          resp_set  = 1'b1;
          resp_err  = 1'b1;
        end
      end
      RESP: begin
        i_ack     = ~owner_d;
        d_ack     = owner_d;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_d    <= 1'b0;
      starve_cnt <= '0;
      wait_cnt   <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_rd_wr    <= 1'b0;
      i_rdata    <= '0;
      i_err      <= 1'b0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
    end else begin
      if (state == IDLE && grant_vld) begin
        owner_d    <= grant_d;
        // A contested data grant implies starve_cnt < STARVE_MAX, so this never wraps.
        starve_cnt <= (grant_d && i_req) ? starve_cnt + 8'd1 : 8'd0;
        if (!grant_misal) begin
          m_addr  <= grant_addr;
          m_wdata <= grant_d ? d_wdata : '0;
          m_rd_wr <= grant_d ? d_rd_wr : 1'b1;
        end
      end
      if (state == MEM && !m_ack && !wait_expired) wait_cnt <= wait_cnt + 16'd1;
      if (state == RESP) wait_cnt <= '0;
      if (resp_set) begin
        if (resp_owner_d) begin
          d_rdata <= resp_rdata;
          d_err   <= resp_err;
        end else begin
          i_rdata <= resp_rdata;
          i_err   <= resp_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small wait-state memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_rd_wr, m_ack;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_ack, i_err, d_ack, d_err, m_req, m_rd_wr;

  mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_rd_wr(d_rd_wr),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_rd_wr(m_rd_wr),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Memory model: acks after mem_wait cycles of m_req; mem_mode 1 never acks.
  logic [31:0] mem [0:255];
  int          mem_wait  = 0;
  bit          mem_mode  = 1'b0;
  bit          force_ack = 1'b0;
  int          mcnt      = 0;

  always @(negedge clk) begin
    m_ack = 1'b0;
    if (m_req && !mem_mode) begin
      if (mcnt == mem_wait) begin
        m_ack = 1'b1;
        if (m_rd_wr) m_rdata = mem[m_addr[9:2]];
        else         mem[m_addr[9:2]] = m_wdata;
        mcnt = 0;
      end else begin
        mcnt++;
      end
    end else if (!m_req) begin
      mcnt = 0;
    end
    if (force_ack) m_ack = 1'b1;
  end

  int          cyc, mreq_n;
  logic        last_rdwr;
  logic [31:0] last_wdata, last_addr;

  // Waits for the requester's ack counting cycles from the request cycle, then drops req.
  task automatic do_access(input bit is_d);
    bit got;
    got = 1'b0;
    cyc = 0;
    mreq_n = 0;
    while (!got && cyc < 50) begin
      @(negedge clk);
      if (m_req) begin
        mreq_n++;
        last_rdwr  = m_rd_wr;
        last_wdata = m_wdata;
        last_addr  = m_addr;
      end
      if (is_d ? d_ack : i_ack) got = 1'b1;
      else cyc++;
    end
    if (!got) check("ack_wait_expired", 32'(got), 32'd1);
    check("ack_excl", 32'(i_ack & d_ack), 32'd0);
    @(posedge clk);
    #1;
    if (is_d) d_req = 1'b0;
    else      i_req = 1'b0;
  endtask

  logic [9:0] order;
  int         ack_cyc [10];
  int         n_ack;
  logic       stray;

  initial begin
    reset = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_rd_wr = 1'b1; m_ack = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
    mem[0] = 32'h27BDFFF8;

    #12;
    check("rst_m_req", 32'(m_req), 32'd0);
    check("rst_i_ack", 32'(i_ack), 32'd0);
    check("rst_d_ack", 32'(d_ack), 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single fetch, zero-wait memory
    i_addr = 32'h80020000; i_req = 1'b1;
    do_access(1'b0);
    check("fetch_cyc", 32'(cyc), 32'd2);
    check("fetch_rdata", i_rdata, 32'h27BDFFF8);
    check("fetch_err", 32'(i_err), 32'd0);
    check("fetch_rdwr", 32'(last_rdwr), 32'd1);
    check("fetch_addr", last_addr, 32'h80020000);

    // Store then load
    d_addr = 32'h8011FFF0; d_wdata = 32'h12345678; d_rd_wr = 1'b0; d_req = 1'b1;
    do_access(1'b1);
    check("store_cyc", 32'(cyc), 32'd2);
    check("store_rdwr", 32'(last_rdwr), 32'd0);
    check("store_wdata", last_wdata, 32'h12345678);
    check("store_rdata", d_rdata, 32'd0);
    check("store_err", 32'(d_err), 32'd0);
    d_wdata = '0; d_rd_wr = 1'b1; d_req = 1'b1;
    do_access(1'b1);
    check("load_rdata", d_rdata, 32'h12345678);
    check("load_rdwr", 32'(last_rdwr), 32'd1);

    // Misaligned data access
    d_addr = 32'h80120002; d_req = 1'b1;
    do_access(1'b1);
    check("misal_cyc", 32'(cyc), 32'd1);
    check("misal_err", 32'(d_err), 32'd1);
    check("misal_rdata", d_rdata, 32'd0);
    check("misal_mreq", 32'(mreq_n), 32'd0);

    // Three memory wait states
    mem_wait = 3;
    d_addr = 32'h8011FFF0; d_req = 1'b1;
    do_access(1'b1);
    check("wait_cyc", 32'(cyc), 32'd5);
    check("wait_err", 32'(d_err), 32'd0);
    check("wait_rdata", d_rdata, 32'h12345678);
    check("wait_mreq", 32'(mreq_n), 32'd4);
    mem_wait = 0;

    // Contention: both requesters held high continuously
    i_addr = 32'h80020000; d_addr = 32'h8011FFF0; d_rd_wr = 1'b1;
    i_req = 1'b1; d_req = 1'b1;
    n_ack = 0; cyc = 0; order = '0;
    while (n_ack < 10 && cyc < 60) begin
      @(negedge clk);
      if (i_ack || d_ack) begin
        check("cont_excl", 32'(i_ack & d_ack), 32'd0);
        if (d_ack) check("cont_d_rdata", d_rdata, 32'h12345678);
        else       check("cont_i_rdata", i_rdata, 32'h27BDFFF8);
        order[n_ack] = d_ack;
        ack_cyc[n_ack] = cyc;
        n_ack++;
      end
      cyc++;
    end
    check("cont_acks", 32'(n_ack), 32'd10);
    @(posedge clk);
    #1;
    i_req = 1'b0; d_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("cont_owner%0d", k), 32'(order[k]), (k % 5 == 4) ? 32'd0 : 32'd1);
      check($sformatf("cont_cyc%0d", k), 32'(ack_cyc[k]), 32'(3 * k + 2));
    end

    // Timeout with memory never acking, then a late m_ack
    mem_mode = 1'b1;
    i_addr = 32'h80020000; i_req = 1'b1;
    do_access(1'b0);
    check("tmo_cyc", 32'(cyc), 32'd9);
    check("tmo_mreq", 32'(mreq_n), 32'd8);
    check("tmo_err", 32'(i_err), 32'd1);
    check("tmo_rdata", i_rdata, 32'd0);
    force_ack = 1'b1;
    stray = 1'b0;
    repeat (3) begin
      @(negedge clk);
      stray = stray | i_ack | d_ack | m_req;
    end
    force_ack = 1'b0;
    check("late_ack_ignored", 32'(stray), 32'd0);

    // Reset asserted mid-MEM
    @(posedge clk);
    #1;
    i_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_mreq_pre", 32'(m_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_m_req", 32'(m_req), 32'd0);
    check("midrst_m_addr", m_addr, 32'd0);
    check("midrst_i_ack", 32'(i_ack), 32'd0);
    check("midrst_d_ack", 32'(d_ack), 32'd0);
    check("midrst_i_err", 32'(i_err), 32'd0);
    check("midrst_d_rdata", d_rdata, 32'd0);
    i_req = 1'b0;
    mem_mode = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    stray = 1'b0;
    repeat (4) begin
      @(negedge clk);
      stray = stray | i_ack | d_ack | m_req;
    end
    check("midrst_no_stale", 32'(stray), 32'd0);

    @(posedge clk);
    #1;
    i_req = 1'b1;
    do_access(1'b0);
    check("post_rst_cyc", 32'(cyc), 32'd2);
    check("post_rst_rdata", i_rdata, 32'h27BDFFF8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one unified memory port between the `mips` core's instruction-fetch path and its load/store path. It accepts one request at a time from each side, issues it on a single req/ack memory interface, and returns a one-cycle acknowledge with read data to the winner. It sits between the core and the memory model or bus bridge. It also provides:
- data-over-instruction priority with a starvation bound;
- misaligned-address rejection;
- a memory timeout.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4. Number of consecutive data grants, made while a fetch is pending, after which the next contested grant goes to the fetch. Range 1..255.
- `TIMEOUT`, default 255. Number of `MEM` cycles without `m_ack` before the access is aborted with an error. Range 1..65535.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `i_req` in 1: fetch request; held until `i_ack`.
- `i_addr` in 32: fetch address; stable while `i_req` is high.
- `i_rdata` out 32: fetched word; valid while `i_ack` is high.
- `i_ack` out 1: one-cycle completion pulse.
- `i_err` out 1: error qualifier; valid with `i_ack`.
- `d_req` in 1: load/store request; held until `d_ack`.
- `d_addr` in 32: data address.
- `d_wdata` in 32: store data.
- `d_rd_wr` in 1: 1 = read, 0 = write.
- `d_rdata` out 32: load data; valid while `d_ack` is high.
- `d_ack` out 1: one-cycle completion pulse.
- `d_err` out 1: error qualifier; valid with `d_ack`.
- `m_req` out 1: memory request.
- `m_addr` out 32: memory address.
- `m_wdata` out 32: memory write data.
- `m_rd_wr` out 1: 1 = read, 0 = write.
- `m_rdata` in 32: memory read data; sampled when `m_ack` is high.
- `m_ack` in 1: memory completion.

## Operation
- States: `IDLE`, `MEM`, `RESP`. Internal owner flag: `I` or `D`.
- **`IDLE`**
  - Requests are sampled only in `IDLE`.
  - If only one request is high, that requester wins.
  - If both are high:
    - `D` wins when `starve_cnt < STARVE_LIMIT`, and `starve_cnt` increments (saturating).
    - Otherwise `I` wins.
  - `starve_cnt` clears whenever `I` is granted.
  - `starve_cnt` also clears when a `D` grant is made with `i_req` low.
  - Fetches are always read; `m_rd_wr` = 1 for an `I` grant.
  - If the winner's `addr[1:0]` ≠ 0:
    - go directly to `RESP` with err = 1;
    - `m_req` is never raised;
    - the winner's `rdata` = 0.
  - Otherwise, register `m_addr`, `m_wdata` and `m_rd_wr` from the winner and go to `MEM`.
- **`MEM`**
  - `m_req` = 1.
  - `m_addr`, `m_wdata` and `m_rd_wr` are held constant.
  - When `m_ack` = 1:
    - capture `m_rdata` into the owner's `rdata`; writes capture 0;
    - set err = 0;
    - go to `RESP`.
  - When `m_ack` = 0:
    - `wait_cnt` increments;
    - when `wait_cnt` reaches `TIMEOUT`, go to `RESP` with err = 1 and `rdata` = 0.
- **`RESP`**
  - Only the owner's `x_ack` = 1, for exactly one cycle.
  - `x_err` and `x_rdata` are valid.
  - `m_req` = 0.
  - Next state is `IDLE`; `wait_cnt` clears.
- **Ignored inputs**
  - `m_ack` outside `MEM` is ignored.
  - Requests in `MEM` or `RESP` are not sampled; they stay pending.
- **Requester rule**
  - A requester that sees `ack` in cycle n must drop `req` in cycle n+1.
  - If `req` is still high in cycle n+1, it is treated as a new request.
- **Output hold**
  - `x_rdata` and `x_err` hold their last values between acks.
  - Checkers must qualify them only with `x_ack`.

## Timing
- **Reset**
  - On `reset` low, asynchronously:
    - state → `IDLE`;
    - `starve_cnt` and `wait_cnt` → 0;
    - all outputs → 0 (`m_req`, `m_addr`, `m_wdata`, `m_rd_wr`, `i_ack`, `i_err`, `i_rdata`, `d_ack`, `d_err`, `d_rdata`).
  - Reset asserted during `MEM` drops `m_req` immediately; no ack is issued for that access.
- **Latency, aligned access with zero-wait memory**
  - Cycle 0: request sampled in `IDLE`.
  - Cycle 1: `m_req` high; memory acks in the same cycle.
  - Cycle 2: `x_ack` high.
  - Each memory wait state adds one cycle.
- **Misaligned access:** `x_ack` in cycle 1, with `m_req` never asserted.
- **Timeout:** `x_ack` with err = 1 occurs `TIMEOUT` + 1 cycles after the grant decision in `IDLE`.
- **Throughput:** a maximum of one access per 3 cycles.
- **Back-to-back:** with both requesters permanently pending and `STARVE_LIMIT` = 4, the grant order is D, D, D, D, I, D, D, D, D, I, …
- **Response exclusivity:** `i_ack` and `d_ack` are never both high in the same cycle.

## Test plan
- **Reset values:** assert `reset` low mid-`MEM`.
  - `m_req`, both acks and all data outputs go to 0 without waiting for `clk`.
  - After release, state is `IDLE` and no stale ack appears.
- **Single fetch:** `i_req` with `i_addr` = 0x80020000; memory acks at cycle 1 with 0x27BDFFF8.
  - `m_rd_wr` = 1.
  - `i_ack` high at cycle 2 with `i_rdata` = 0x27BDFFF8 and `i_err` = 0.
- **Store then load:**
  - Store: `d_rd_wr` = 0, `d_addr` = 0x8011FFF0, `d_wdata` = 0x12345678.
    - `m_rd_wr` = 0 and `m_wdata` = 0x12345678 during `MEM`.
    - `d_ack` with `d_rdata` = 0.
  - Load from the same address: `d_rdata` = 0x12345678.
- **Contention and starvation:** hold `i_req` and `d_req` continuously with zero-wait memory.
  - Grant order is D, D, D, D, I, repeating.
  - The fetch gets its ack within 15 cycles.
- **Misaligned:** `d_addr` = 0x80120002.
  - `d_ack` and `d_err` = 1 at cycle 1.
  - `m_req` stays 0 throughout.
- **Timeout and wait states:**
  - Memory with 3 wait states: ack at cycle 5 with err = 0.
  - With `TIMEOUT` = 8 and memory never acking: `m_req` is high for 8 cycles, then `x_err` = 1.
  - A late `m_ack` after the abort is ignored.
